// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Brief    : Shared constants for the digit-serial subtractor: FSM state
//             encoding, default operand/digit widths, counter sizing helper.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_N_DEFAULT     = 16;
    localparam int c_DIGIT_DEFAULT = 4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Width of a counter that must index steps-1; never narrower than 1 bit.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : digit_subtractor
//  Brief    : Combinational DIGIT-bit subtract with borrow-in/borrow-out.
//             d = a - b - bin (mod 2^DIGIT), bout = 1 when the result
//             went negative.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One extra bit catches the wrap below zero, which is exactly the borrow.
    logic [DIGIT:0] w_full;

    assign w_full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign d      = w_full[DIGIT-1:0];
    assign bout   = w_full[DIGIT];

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Digit-serial unsigned subtractor, diff = x - y - bin (mod 2^N),
//             DIGIT bits per clock, LSB slice first, valid/ready on both
//             the operand and the result side.
//             Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the
//             signed-overflow output ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N     = c_N_DEFAULT,
    parameter int DIGIT = c_DIGIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic         ovf,
`endif
    output logic         done_valid,
    input  logic         done_ready
);

    localparam int              c_STEPS = N / DIGIT;
    localparam int              c_CW    = cnt_width(c_STEPS);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_STEPS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_capture;
    logic             w_step;
    logic             w_last;

    logic [N-1:0]     r_x;
    logic [N-1:0]     r_y;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [c_CW-1:0]  r_cnt;

    logic [DIGIT-1:0] w_slice_d;
    logic             w_slice_bout;
    logic [N-1:0]     w_acc_nxt;

    assign w_last = (r_cnt == c_LAST);

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; start_valid is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Operands shift right each step, so the active slice is always bits [DIGIT-1:0].
    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (r_x[DIGIT-1:0]),
        .b    (r_y[DIGIT-1:0]),
        .bin  (r_borrow),
        .d    (w_slice_d),
        .bout (w_slice_bout)
    );

    // New slice enters at the top of the accumulator; after the last step it is fully aligned.
    generate
        if (DIGIT == N) begin : g_acc_single
            assign w_acc_nxt = w_slice_d;
        end else begin : g_acc_shift
            assign w_acc_nxt = {w_slice_d, r_acc[N-1:DIGIT]};
        end
    endgenerate

    // Datapath: capture on handshake, one slice per BUSY cycle, publish result on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_capture) begin
            r_x      <= x;
            r_y      <= y;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_x      <= r_x >> DIGIT;
            r_y      <= r_y >> DIGIT;
            r_acc    <= w_acc_nxt;
            r_borrow <= w_slice_bout;
            r_cnt    <= r_cnt + c_CW'(1);
            if (w_last) begin
                r_diff <= w_acc_nxt;
                r_bout <= w_slice_bout;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_ovf;

    // On the last step the live slice holds the original sign bits of x and y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_last) begin
            r_ovf <= (r_x[DIGIT-1] != r_y[DIGIT-1]) &&
                     (w_slice_d[DIGIT-1] != r_x[DIGIT-1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: Parameter N SHALL be declared as: N, default 16, operand and result width in bits.
REQ-002: Parameter DIGIT SHALL be declared as: DIGIT, default 4, bits processed per clock cycle; N SHALL be an integer multiple of DIGIT.
REQ-003: Port clk SHALL be declared as: clk  input  1  sole clock, rising edge.
REQ-004: Port rst_n SHALL be declared as: rst_n  input  1  synchronous, active-low reset.
REQ-005: Port start_valid SHALL be declared as: start_valid  input  1  operands present.
REQ-006: Port start_ready SHALL be declared as: start_ready  output  1  block can accept operands.
REQ-007: Port x SHALL be declared as: x  input  N  minuend.
REQ-008: Port y SHALL be declared as: y  input  N  subtrahend.
REQ-009: Port bin SHALL be declared as: bin  input  1  borrow-in.
REQ-010: Port diff SHALL be declared as: diff  output  N  result, x - y - bin modulo 2^N.
REQ-011: Port bout SHALL be declared as: bout  output  1  borrow-out; 1 iff x < y + bin, unsigned.
REQ-012: Port done_valid SHALL be declared as: done_valid  output  1  result valid.
REQ-013: Port done_ready SHALL be declared as: done_ready  input  1  consumer accepts the result.

Function
REQ-014: The FSM SHALL have three states, IDLE, BUSY and DONE; start_ready SHALL be 1 only in IDLE, and done_valid SHALL be 1 only in DONE.
REQ-015: In IDLE, a start handshake (start_valid and start_ready both 1) SHALL capture x, y and bin, clear the digit counter and move to BUSY; in IDLE with start_valid=0 the block SHALL stay in IDLE.
REQ-016: Each BUSY cycle SHALL subtract one DIGIT-wide slice, LSB slice first, using the running borrow (seeded with bin), store the slice result, update the borrow and increment the counter.
REQ-017: After the slice N-DIGIT has been processed, the FSM SHALL move to DONE; done_valid SHALL rise exactly N/DIGIT cycles after the handshake edge (4 cycles for 16/4, 17 cycles for 34/2).
REQ-018: In DONE, diff, bout and done_valid SHALL stay stable until done_ready=1, after which the FSM SHALL return to IDLE on that edge.
REQ-019: With done_ready held at 1, DONE SHALL last exactly one cycle, giving a throughput of one operation per N/DIGIT+2 cycles.
REQ-020: start_valid while in BUSY or DONE SHALL be ignored, with no capture and no state change.
REQ-021: diff and bout SHALL change only when the FSM enters DONE; while in IDLE or BUSY they SHALL hold the previous result.

Reset
REQ-022: When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and diff, bout, done_valid, the counter, the borrow and all operand registers SHALL be cleared to 0.
REQ-023: A reset asserted in BUSY or DONE SHALL discard the operation in flight; start_ready SHALL read 1 on the first edge after rst_n returns to 1.

Configuration
REQ-024: When macro SERIAL_SUB_OVERFLOW_EN is defined, the block SHALL add output port ovf (1 bit, reset 0), updated with diff, which SHALL be 1 iff x[N-1] differs from y[N-1] and diff[N-1] differs from x[N-1].
REQ-025: When SERIAL_SUB_OVERFLOW_EN is not defined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026: Package serial_sub_pkg SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default values of N and DIGIT.
REQ-027: One combinational sub-module, digit_subtractor (parameter DIGIT; ports a, b, bin, d, bout), SHALL perform the per-cycle slice subtraction and SHALL be instantiated once.

Verification
REQ-028: With N=16 and DIGIT=4, the bench SHALL check: x=0x1234, y=0x0234, bin=0 -> diff=0x1000, bout=0, done_valid exactly 4 cycles after the handshake.
REQ-029: With N=16, the bench SHALL check: x=0x0000, y=0x0001, bin=0 -> diff=0xFFFF, bout=1; and x=0x0005, y=0x0005, bin=1 -> diff=0xFFFF, bout=1.
REQ-030: With N=16, the bench SHALL check: x=0x8000, y=0x0001 -> diff=0x7FFF, bout=0, and ovf=1 when SERIAL_SUB_OVERFLOW_EN is defined.
REQ-031: The bench SHALL hold done_ready=0 for 5 cycles in DONE and check that diff and bout stay stable, start_ready=0, and a start_valid pulse is ignored.
REQ-032: The bench SHALL pulse rst_n=0 for one cycle during the second BUSY cycle and check that the next edge gives IDLE, all outputs 0, and that a following operation completes correctly.
REQ-033: With N=34 and DIGIT=2, the bench SHALL check: x=0x2_0000_0000, y=1, bin=0 -> diff=0x1_FFFF_FFFF, bout=0, done_valid 17 cycles after the handshake.
